// File: rtl/shunt_fringe_pkg.sv
// Shared types, default widths and helpers for the fringe endpoint.
package shunt_fringe_pkg;

   localparam int FRNG_N_OF_SIGNALS = 8;
   localparam int FRNG_DATA_BIT     = 32;
   localparam int FRNG_ID_W         = 8;

   typedef enum logic [1:0] {
      TARGET_IDLE      = 2'd0,
      INITIATOR_ACTIVE = 2'd1,
      TARGET_ACTIVE    = 2'd2,
      INITIATOR_IDLE   = 2'd3
   } frng_status_e;

   typedef enum logic {
      FRNG_PORT_INPUT  = 1'b0,
      FRNG_PORT_OUTPUT = 1'b1
   } frng_port_e;

   typedef enum logic {
      FRNG_SIG_INVALID = 1'b0,
      FRNG_SIG_VALID   = 1'b1
   } frng_signal_valid_e;

   typedef logic [FRNG_DATA_BIT-1:0] data_in_t;

   // Only an active node may drive traffic onto the link.
   function automatic logic frng_is_active(input logic [1:0] st);
      return (st == INITIATOR_ACTIVE) || (st == TARGET_ACTIVE);
   endfunction

endpackage

// File: rtl/shunt_fringe_mailbox.sv
// One signal's inbound mailbox: latched data, valid flag and sticky overrun.
// Inbound data always wins over a same-cycle get or clear.
module shunt_fringe_mailbox
   import shunt_fringe_pkg::*;
#(
   parameter int DATA_W = FRNG_DATA_BIT
) (
   input  logic              i_clk,
   input  logic              reset,
   input  logic              in_en,
   input  logic [DATA_W-1:0] in_data,
   input  logic              get_en,
   input  logic              clr,
   output logic              valid,
   output logic [DATA_W-1:0] data,
   output logic              overrun
);

   frng_signal_valid_e valid_q;

   assign valid = (valid_q == FRNG_SIG_VALID);

   always_ff @(posedge i_clk) begin
      if (reset) begin
         valid_q <= FRNG_SIG_INVALID;
         data    <= '0;
         overrun <= 1'b0;
      end else if (in_en) begin
         data    <= in_data;
         valid_q <= FRNG_SIG_VALID;
         // A get in the same cycle consumes the old word, so nothing is lost.
         if (valid_q == FRNG_SIG_VALID && !get_en) overrun <= 1'b1;
      end else if (get_en || clr) begin
         valid_q <= FRNG_SIG_INVALID;
      end
   end

endmodule

// File: rtl/shunt_fringe_if_core.sv
// Fringe endpoint: identity, per-signal routing table, outbound put path, inbound mailboxes.
// Optional FRNG_TIME_CNT_EN adds a free-running 64-bit time_cnt output.
module shunt_fringe_if_core
   import shunt_fringe_pkg::*;
#(
   parameter  int N_SIGNALS = FRNG_N_OF_SIGNALS,
   parameter  int DATA_W    = FRNG_DATA_BIT,
   parameter  int ID_W      = FRNG_ID_W,
   localparam int IDX_W     = $clog2(N_SIGNALS)
) (
   input  logic                 i_clk,
   input  logic                 reset,
   input  logic                 iam_we,
   input  logic [ID_W-1:0]      iam_wdata,
   input  logic                 status_we,
   input  logic [1:0]           status_wdata,
   input  logic                 simid_we,
   input  logic [ID_W-1:0]      simid_wdata,
   input  logic                 cfg_we,
   input  logic [IDX_W-1:0]     cfg_idx,
   input  logic                 cfg_port,
   input  logic [ID_W-1:0]      cfg_parent,
   input  logic                 put_valid,
   input  logic [IDX_W-1:0]     put_idx,
   input  logic [DATA_W-1:0]    put_data,
   output logic                 put_ready,
   output logic                 put_err,
   output logic                 out_valid,
   output logic [ID_W-1:0]      out_dst,
   output logic [IDX_W-1:0]     out_idx,
   output logic [DATA_W-1:0]    out_data,
   input  logic                 out_ready,
   input  logic                 in_valid,
   input  logic [IDX_W-1:0]     in_idx,
   input  logic [DATA_W-1:0]    in_data,
   input  logic                 get_req,
   input  logic [IDX_W-1:0]     get_idx,
   output logic                 get_success,
   output logic [DATA_W-1:0]    get_data,
   output logic [N_SIGNALS-1:0] overrun,
   output logic [ID_W-1:0]      my_id,
   output logic [1:0]           my_status,
   output logic [ID_W-1:0]      simid
`ifdef FRNG_TIME_CNT_EN
   ,
   output logic [63:0]          time_cnt
`endif
);

   frng_status_e                         status_q;
   logic [N_SIGNALS-1:0]                 port_q;
   logic [N_SIGNALS-1:0][ID_W-1:0]       parent_q;
   logic [N_SIGNALS-1:0]                 cfg_sel, put_sel, in_sel, get_sel;
   logic [N_SIGNALS-1:0]                 mb_valid;
   logic [N_SIGNALS-1:0][DATA_W-1:0]     mb_data;

   logic              put_port, put_fire, put_ok, get_hit;
   logic [ID_W-1:0]   put_parent;
   logic [DATA_W-1:0] get_word;

   assign my_status = status_q;

   // One-hot decode; an index with no matching entry selects nothing.
   for (genvar g = 0; g < N_SIGNALS; g++) begin : g_sig
      assign cfg_sel[g] = (cfg_idx == IDX_W'(g));
      assign put_sel[g] = (put_idx == IDX_W'(g));
      assign in_sel[g]  = (in_idx  == IDX_W'(g));
      assign get_sel[g] = (get_idx == IDX_W'(g));

      shunt_fringe_mailbox #(.DATA_W(DATA_W)) u_mb (
         .i_clk   (i_clk),
         .reset   (reset),
         .in_en   (in_valid && in_sel[g] && (port_q[g] == FRNG_PORT_INPUT)),
         .in_data (in_data),
         .get_en  (get_req && get_sel[g]),
         .clr     (cfg_we && cfg_sel[g]),
         .valid   (mb_valid[g]),
         .data    (mb_data[g]),
         .overrun (overrun[g])
      );
   end

   always_comb begin
      put_port   = FRNG_PORT_INPUT;
      put_parent = '0;
      get_hit    = 1'b0;
      get_word   = '0;
      for (int i = 0; i < N_SIGNALS; i++) begin
         if (put_sel[i]) begin
            put_port   = port_q[i];
            put_parent = parent_q[i];
         end
         if (get_sel[i]) begin
            get_hit  = mb_valid[i];
            get_word = mb_data[i];
         end
      end
   end

   assign put_ready = !out_valid || out_ready;
   assign put_fire  = put_valid && put_ready;
   assign put_ok    = (put_port == FRNG_PORT_OUTPUT) && (put_parent != my_id)
                      && frng_is_active(status_q);

   always_ff @(posedge i_clk) begin
      if (reset) begin
         my_id       <= '0;
         status_q    <= TARGET_IDLE;
         simid       <= '0;
         port_q      <= '0;
         parent_q    <= '0;
         out_valid   <= 1'b0;
         out_dst     <= '0;
         out_idx     <= '0;
         out_data    <= '0;
         put_err     <= 1'b0;
         get_success <= 1'b0;
         get_data    <= '0;
      end else begin
         if (iam_we)    my_id    <= iam_wdata;
         if (status_we) status_q <= frng_status_e'(status_wdata);
         if (simid_we)  simid    <= simid_wdata;
         for (int i = 0; i < N_SIGNALS; i++) begin
            if (cfg_we && cfg_sel[i]) begin
               port_q[i]   <= cfg_port;
               parent_q[i] <= cfg_parent;
            end
         end

         put_err <= put_fire && !put_ok;
         // A new accepted put refills the slot even on the handshake cycle.
         if (put_fire && put_ok) begin
            out_valid <= 1'b1;
            out_dst   <= put_parent;
            out_idx   <= put_idx;
            out_data  <= put_data;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end

         get_success <= get_req && get_hit;
         get_data    <= (get_req && get_hit) ? get_word : '0;
      end
   end

`ifdef FRNG_TIME_CNT_EN
   always_ff @(posedge i_clk) begin
      if (reset) time_cnt <= '0;
      else       time_cnt <= time_cnt + 64'd1;
   end
`endif

endmodule

// File: tb/tb_shunt_fringe_if_core.sv
// Self-checking bench for shunt_fringe_if_core: vector table plus scoreboard queues.
`timescale 1ns/1ps
module tb_shunt_fringe_if_core;
   import shunt_fringe_pkg::*;

   localparam int N  = 8;
   localparam int DW = 32;
   localparam int IW = 8;
   localparam int XW = 3;

   logic          i_clk = 1'b0;
   logic          reset;
   logic          iam_we, status_we, simid_we, cfg_we, cfg_port;
   logic [IW-1:0] iam_wdata, simid_wdata, cfg_parent;
   logic [1:0]    status_wdata;
   logic [XW-1:0] cfg_idx, put_idx, in_idx, get_idx, out_idx;
   logic          put_valid, put_ready, put_err, out_valid, out_ready;
   logic          in_valid, get_req, get_success;
   logic [DW-1:0] put_data, out_data, in_data, get_data;
   logic [IW-1:0] out_dst, my_id, simid;
   logic [1:0]    my_status;
   logic [N-1:0]  overrun;
`ifdef FRNG_TIME_CNT_EN
   logic [63:0]   time_cnt;
`endif

   always #5 i_clk = ~i_clk;

   shunt_fringe_if_core #(.N_SIGNALS(N), .DATA_W(DW), .ID_W(IW)) dut (
      .i_clk(i_clk), .reset(reset),
      .iam_we(iam_we), .iam_wdata(iam_wdata),
      .status_we(status_we), .status_wdata(status_wdata),
      .simid_we(simid_we), .simid_wdata(simid_wdata),
      .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_port(cfg_port), .cfg_parent(cfg_parent),
      .put_valid(put_valid), .put_idx(put_idx), .put_data(put_data),
      .put_ready(put_ready), .put_err(put_err),
      .out_valid(out_valid), .out_dst(out_dst), .out_idx(out_idx), .out_data(out_data),
      .out_ready(out_ready),
      .in_valid(in_valid), .in_idx(in_idx), .in_data(in_data),
      .get_req(get_req), .get_idx(get_idx),
      .get_success(get_success), .get_data(get_data),
      .overrun(overrun), .my_id(my_id), .my_status(my_status), .simid(simid)
`ifdef FRNG_TIME_CNT_EN
      , .time_cnt(time_cnt)
`endif
   );

   typedef enum int {K_ID, K_SIM, K_ST, K_CFG, K_IN, K_GET, K_PUT} kind_e;
   // par: parent for CFG, value for ID/SIM/ST, expected destination for PUT.
   // ea: expected put_err for PUT, expected get_success for GET.
   typedef struct {
      kind_e         k;
      logic [XW-1:0] idx;
      logic [IW-1:0] par;
      logic [DW-1:0] d;
      logic          port;
      logic          ea;
      logic [DW-1:0] ed;
   } vec_t;
   typedef struct packed { logic s; logic [DW-1:0] d; } get_exp_t;
   typedef struct packed { logic [IW-1:0] dst; logic [XW-1:0] idx; logic [DW-1:0] d; } out_exp_t;

   get_exp_t gq[$];
   out_exp_t oq[$];
   logic     eq[$];
   vec_t     tbl[$];
   int       checks = 0;
   int       failures = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input kind_e k, input int idx, input int par, input logic [DW-1:0] d,
                               input logic port, input logic ea, input logic [DW-1:0] ed);
      vec_t v;
      v.k = k; v.idx = idx[XW-1:0]; v.par = par[IW-1:0];
      v.d = d; v.port = port; v.ea = ea; v.ed = ed;
      return v;
   endfunction

   task automatic idle();
      iam_we = 0; status_we = 0; simid_we = 0; cfg_we = 0;
      put_valid = 0; in_valid = 0; get_req = 0;
      iam_wdata = '0; status_wdata = '0; simid_wdata = '0;
      cfg_idx = '0; cfg_port = 0; cfg_parent = '0;
      put_idx = '0; put_data = '0; in_idx = '0; in_data = '0; get_idx = '0;
   endtask

   task automatic sb_get();
      get_exp_t g;
      if (gq.size() == 0) begin
         chk("get_queue_empty", 64'd1, 64'd0);
      end else begin
         g = gq.pop_front();
         chk("get_success", 64'(get_success), 64'(g.s));
         chk("get_data", 64'(get_data), 64'(g.d));
      end
   endtask

   task automatic sb_put();
      out_exp_t o;
      logic     e;
      e = eq.pop_front();
      chk("put_err", 64'(put_err), 64'(e));
      if (!e) begin
         o = oq.pop_front();
         chk("out_valid", 64'(out_valid), 64'd1);
         chk("out_dst", 64'(out_dst), 64'(o.dst));
         chk("out_idx", 64'(out_idx), 64'(o.idx));
         chk("out_data", 64'(out_data), 64'(o.d));
      end else begin
         chk("out_valid_after_err", 64'(out_valid), 64'd0);
      end
   endtask

   // Called at a negedge; drives one cycle of stimulus and scores the result.
   task automatic apply(input vec_t v);
      case (v.k)
         K_ID:  begin iam_we = 1; iam_wdata = v.par; end
         K_SIM: begin simid_we = 1; simid_wdata = v.par; end
         K_ST:  begin status_we = 1; status_wdata = v.par[1:0]; end
         K_CFG: begin cfg_we = 1; cfg_idx = v.idx; cfg_port = v.port; cfg_parent = v.par; end
         K_IN:  begin in_valid = 1; in_idx = v.idx; in_data = v.d; end
         K_GET: begin get_req = 1; get_idx = v.idx; gq.push_back({v.ea, v.ed}); end
         K_PUT: begin
            put_valid = 1; put_idx = v.idx; put_data = v.d;
            eq.push_back(v.ea);
            if (!v.ea) oq.push_back({v.par, v.idx, v.d});
         end
         default: ;
      endcase
      @(posedge i_clk); #1; idle();
      @(negedge i_clk);
      if (v.k == K_GET) sb_get();
      if (v.k == K_PUT) sb_put();
   endtask

   initial begin
      idle();
      out_ready = 1;
      reset = 1;
      repeat (3) @(posedge i_clk);
      #1 reset = 0;
      @(negedge i_clk);
      chk("rst_my_id", 64'(my_id), 64'd0);
      chk("rst_status", 64'(my_status), 64'd0);
      chk("rst_simid", 64'(simid), 64'd0);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_put_err", 64'(put_err), 64'd0);
      chk("rst_get_success", 64'(get_success), 64'd0);
      chk("rst_get_data", 64'(get_data), 64'd0);
      chk("rst_overrun", 64'(overrun), 64'd0);
      chk("rst_put_ready", 64'(put_ready), 64'd1);
`ifdef FRNG_TIME_CNT_EN
      chk("rst_time_cnt", time_cnt, 64'd0);
      repeat (4) @(negedge i_clk);
      chk("time_cnt_run", time_cnt, 64'd4);
`endif

      tbl.push_back(mk(K_ID,  0, 1,    0, 0, 0, 0));
      tbl.push_back(mk(K_SIM, 0, 'h42, 0, 0, 0, 0));
      tbl.push_back(mk(K_ST,  0, 1,    0, 0, 0, 0));
      tbl.push_back(mk(K_CFG, 2, 3,    0, 1, 0, 0));
      tbl.push_back(mk(K_PUT, 2, 3,    'hA5, 0, 0, 0));
      tbl.push_back(mk(K_CFG, 2, 1,    0, 1, 0, 0));
      tbl.push_back(mk(K_PUT, 2, 0,    'h5A, 0, 1, 0));
      tbl.push_back(mk(K_PUT, 0, 0,    'h11, 0, 1, 0));
      tbl.push_back(mk(K_CFG, 5, 7,    0, 1, 0, 0));
      tbl.push_back(mk(K_ST,  0, 3,    0, 0, 0, 0));
      tbl.push_back(mk(K_PUT, 5, 0,    'h33, 0, 1, 0));
      tbl.push_back(mk(K_ST,  0, 2,    0, 0, 0, 0));
      tbl.push_back(mk(K_PUT, 5, 7,    'h44, 0, 0, 0));
      tbl.push_back(mk(K_GET, 0, 0,    0, 0, 0, 0));
      tbl.push_back(mk(K_IN,  0, 0,    'h1, 0, 0, 0));
      tbl.push_back(mk(K_GET, 0, 0,    0, 0, 1, 'h1));
      tbl.push_back(mk(K_GET, 0, 0,    0, 0, 0, 0));
      tbl.push_back(mk(K_IN,  0, 0,    'h1, 0, 0, 0));
      tbl.push_back(mk(K_IN,  0, 0,    'h2, 0, 0, 0));
      tbl.push_back(mk(K_GET, 0, 0,    0, 0, 1, 'h2));
      tbl.push_back(mk(K_IN,  5, 0,    'h99, 0, 0, 0));
      tbl.push_back(mk(K_GET, 5, 0,    0, 0, 0, 0));
      tbl.push_back(mk(K_IN,  6, 0,    'hDEAD, 0, 0, 0));
      tbl.push_back(mk(K_CFG, 6, 0,    0, 0, 0, 0));
      tbl.push_back(mk(K_GET, 6, 0,    0, 0, 0, 0));
      tbl.push_back(mk(K_IN,  3, 0,    'hBEEF, 0, 0, 0));
      tbl.push_back(mk(K_GET, 3, 0,    0, 0, 1, 'hBEEF));
      tbl.push_back(mk(K_IN,  4, 0,    'h3, 0, 0, 0));
      foreach (tbl[i]) apply(tbl[i]);

      chk("id_my_id", 64'(my_id), 64'd1);
      chk("id_simid", 64'(simid), 64'h42);
      chk("id_status", 64'(my_status), 64'd2);
      chk("overrun_idx0", 64'(overrun), 64'h01);

      // Same-cycle inbound and get on idx4: get sees old word, new word kept.
      in_valid = 1; in_idx = 3'd4; in_data = 32'h7;
      get_req = 1; get_idx = 3'd4; gq.push_back({1'b1, 32'h3});
      @(posedge i_clk); #1; idle();
      @(negedge i_clk);
      sb_get();
      apply(mk(K_GET, 4, 0, 0, 0, 1, 'h7));
      chk("overrun_same_cycle", 64'(overrun), 64'h01);

      // Backpressure: slot must hold while the transport stalls.
      out_ready = 0;
      put_valid = 1; put_idx = 3'd5; put_data = 32'h55;
      @(posedge i_clk); #1;
      put_data = 32'h66;
      @(negedge i_clk);
      chk("bp_load_valid", 64'(out_valid), 64'd1);
      chk("bp_load_ready", 64'(put_ready), 64'd0);
      for (int c = 0; c < 5; c++) begin
         @(negedge i_clk);
         chk("bp_hold_valid", 64'(out_valid), 64'd1);
         chk("bp_hold_data", 64'(out_data), 64'h55);
         chk("bp_hold_dst", 64'(out_dst), 64'd7);
         chk("bp_hold_ready", 64'(put_ready), 64'd0);
         chk("bp_hold_err", 64'(put_err), 64'd0);
      end
      put_valid = 0;
      out_ready = 1;
      @(posedge i_clk); #1;
      @(negedge i_clk);
      chk("bp_release_valid", 64'(out_valid), 64'd0);
      chk("bp_release_ready", 64'(put_ready), 64'd1);

      // Refill on the handshake cycle keeps the slot full with the new word.
      put_valid = 1; put_idx = 3'd5; put_data = 32'h77;
      @(posedge i_clk); #1;
      put_data = 32'h88;
      @(posedge i_clk); #1; idle();
      @(negedge i_clk);
      chk("refill_valid", 64'(out_valid), 64'd1);
      chk("refill_data", 64'(out_data), 64'h88);
      @(negedge i_clk);
      chk("refill_drain", 64'(out_valid), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
